// File: rtl/bitstream_packer_if.sv
// Handshake bundle between the entropy-encoder carry stage and the
// bitstream packer: a byte-lane input side and a word-wide output side.
interface bitstream_packer_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int IN_LANES   = 3,
    parameter int OUT_BYTES  = 4
);
    logic                            in_valid;
    logic [2:0]                      in_count;
    logic [IN_LANES*BYTE_WIDTH-1:0]  in_bytes;
    logic                            in_last;
    logic                            in_ready;
    logic                            out_valid;
    logic                            out_ready;
    logic [OUT_BYTES*BYTE_WIDTH-1:0] out_data;
    logic [OUT_BYTES-1:0]            out_keep;
    logic                            out_last;

    // Producer of bytes / consumer of words
    modport master (
        output in_valid, in_count, in_bytes, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    // The packer itself
    modport slave (
        input  in_valid, in_count, in_bytes, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/bitstream_packer.sv
// Byte-stream packer: buffers 0..IN_LANES bytes per cycle in a circular
// byte FIFO and emits OUT_BYTES-wide words; a frame-final flush emits the
// partial tail word. Overflow (input while not ready) is a sticky error.
// Optional per-frame popped-byte counter: define PACKER_BYTE_COUNT_EN.
module bitstream_packer #(
    parameter int BYTE_WIDTH = 8,
    parameter int IN_LANES   = 3,
    parameter int OUT_BYTES  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_WIDTH  = 5
) (
    input  logic                 top_clk,
    input  logic                 top_reset_n,
    bitstream_packer_if.slave    bus,
    output logic                 out_error,
`ifdef PACKER_BYTE_COUNT_EN
    output logic [LVL_WIDTH-1:0] fifo_level,
    output logic [31:0]          out_byte_count
`else
    output logic [LVL_WIDTH-1:0] fifo_level
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_WIDTH-1:0] LANES_L  = LVL_WIDTH'(IN_LANES);
    localparam logic [LVL_WIDTH-1:0] OUT_L    = LVL_WIDTH'(OUT_BYTES);
    localparam logic [LVL_WIDTH-1:0] ROOM_MAX = LVL_WIDTH'(FIFO_DEPTH - IN_LANES);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BYTE_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_WIDTH-1:0]    level;
    logic [LVL_WIDTH-1:0]    level_next;
    logic [LVL_WIDTH-1:0]    req_cnt;
    logic [LVL_WIDTH-1:0]    wr_cnt;
    logic [LVL_WIDTH-1:0]    avail;
    logic [LVL_WIDTH-1:0]    pop_amt;
    logic                    wr_en;
    logic                    overflow;
    logic                    pop;

    assign fifo_level = level;

    // Input acceptance, write amount and the bytes available for one word
    always_comb begin
        bus.in_ready = (state == RUN) && (level <= ROOM_MAX);
        wr_en        = bus.in_valid && bus.in_ready;
        overflow     = bus.in_valid && !bus.in_ready;
        req_cnt      = LVL_WIDTH'(bus.in_count);
        wr_cnt       = '0;
        if (wr_en) begin
            wr_cnt = (req_cnt > LANES_L) ? LANES_L : req_cnt;
        end
        avail = (level < OUT_L) ? level : OUT_L;
    end

    // Output word view at rd_ptr; storage beyond the keep mask is shown raw
    always_comb begin
        bus.out_data = '0;
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            bus.out_data[i*BYTE_WIDTH +: BYTE_WIDTH] = mem[rd_ptr + PTR_W'(i)];
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next    = state;
        bus.out_valid = 1'b0;
        bus.out_keep  = '0;
        bus.out_last  = 1'b0;
        pop           = 1'b0;
        pop_amt       = '0;
        case (state)
            RUN: begin
                bus.out_valid = (level >= OUT_L);
                // Keep reads zero while idle so the reset view is all-zero
                bus.out_keep  = bus.out_valid ? '1 : '0;
                if (wr_en && bus.in_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                bus.out_valid = 1'b1;
                for (int unsigned i = 0; i < OUT_BYTES; i++) begin
                    bus.out_keep[i] = (LVL_WIDTH'(i) < avail);
                end
                bus.out_last = (level <= OUT_L);
            end
            default: state_next = RUN;
        endcase
        pop = bus.out_valid && bus.out_ready;
        if (pop) begin
            pop_amt = avail;
        end
        if (state == FLUSH && pop && bus.out_last) begin
            state_next = RUN;
        end
        level_next = level + wr_cnt - pop_amt;
    end

    // State, pointers, level and the sticky overflow flag
    always_ff @(posedge top_clk or negedge top_reset_n) begin
        if (!top_reset_n) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_error <= 1'b0;
        end else begin
            state  <= state_next;
            level  <= level_next;
            wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop_amt);
            if (overflow) begin
                out_error <= 1'b1;
            end
        end
    end

    // Byte storage: lanes 0..wr_cnt-1 land at consecutive wrapped addresses
    always_ff @(posedge top_clk or negedge top_reset_n) begin
        if (!top_reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < IN_LANES; i++) begin
                if (LVL_WIDTH'(i) < wr_cnt) begin
                    mem[wr_ptr + PTR_W'(i)] <= bus.in_bytes[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

`ifdef PACKER_BYTE_COUNT_EN
    logic [31:0] byte_acc;
    logic [32:0] byte_sum;

    // Count includes the beat being popped now, so the final beat shows the frame total
    always_comb begin
        byte_sum       = {1'b0, byte_acc} + 33'(pop_amt);
        out_byte_count = byte_sum[32] ? '1 : byte_sum[31:0];
    end

    // Per-frame accumulator, cleared by the out_last handshake
    always_ff @(posedge top_clk or negedge top_reset_n) begin
        if (!top_reset_n) begin
            byte_acc <= '0;
        end else if (pop && bus.out_last) begin
            byte_acc <= '0;
        end else begin
            byte_acc <= out_byte_count;
        end
    end
`endif

endmodule
